// File: rtl/hamming_tx_pkg.sv
// Shared types and helpers for the Hamming(7,4) serial transmitter:
// FSM state encoding, parity function and line levels.
package hamming_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_FLAG,
        ST_STOP
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Returns {p3, p2, p1}, matching the convention of the upstream register.
    function automatic logic [2:0] hamming74_parity(input logic [3:0] d);
        return {d[0] ^ d[1] ^ d[2],
                d[0] ^ d[1] ^ d[3],
                d[0] ^ d[2] ^ d[3]};
    endfunction

    function automatic int frame_bits(input int blocks);
        return 7 * blocks + 3;
    endfunction

endpackage

// File: rtl/hamming74_encoder.sv
// Combinational Hamming(7,4) encoder; codeword bit 0 is the first bit on the line
// (d0, d1, d2, d3, p1, p2, p3).
module hamming74_encoder
    import hamming_tx_pkg::*;
(
    input  logic [3:0] data_i,
    output logic [6:0] code_o
);

    assign code_o = {hamming74_parity(data_i), data_i};

endmodule

// File: rtl/hamming_serial_tx.sv
// Accepts a word over valid/ready, Hamming(7,4)-encodes each nibble and sends
// start bit, codewords, fault flag and stop bit on an idle-high serial line.
module hamming_serial_tx
    import hamming_tx_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_fault,
    output logic             in_ready,
    output logic             tx_out,
    output logic             tx_busy,
    output logic [15:0]      frame_count
);

    localparam int BLOCKS    = WIDTH / 4;
    localparam int DATA_BITS = 7 * BLOCKS;
    localparam int SHIFT_W   = DATA_BITS + 1;
    localparam int DIV_W     = $clog2(CLKS_PER_BIT);
    localparam int CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_BITS - 1);

    logic [DATA_BITS-1:0] codes;

    for (genvar i = 0; i < BLOCKS; i++) begin : g_enc
        hamming74_encoder u_enc (
            .data_i (in_data[4*i +: 4]),
            .code_o (codes[7*i +: 7])
        );
    end

    tx_state_t          state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [15:0]        fc_q, fc_d;
    logic               bit_tick;

    assign bit_tick    = (div_q == DIV_LAST);
    assign in_ready    = (state_q == ST_IDLE) && !rst;
    assign tx_busy     = (state_q != ST_IDLE);
    assign tx_out      = tx_q;
    assign frame_count = fc_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            // NOTE: the shift register is cleared too, so an abandoned frame leaves no stale data.
            shift_q <= '0;
            tx_q    <= LINE_IDLE;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            fc_q    <= fc_d;
        end
    end

    // tx_d follows the current state, so the line lags the FSM by one cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        fc_d    = fc_q;
        tx_d    = LINE_IDLE;

        if (state_q != ST_IDLE) begin
            div_d = bit_tick ? '0 : div_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = ST_START;
                    shift_d = {in_fault, codes};
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                tx_d = LINE_START;
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_FLAG;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_FLAG: begin
                tx_d = shift_q[0];
                if (bit_tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                tx_d = LINE_STOP;
                if (bit_tick) begin
                    state_d = ST_IDLE;
                    fc_d    = fc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Scoreboard bench for hamming_serial_tx: 4-bit and 8-bit instances, line
// monitors decode frames and compare against a reference model queue.
module tb_hamming_serial_tx;

    localparam int CPB = 4;
    localparam int FB4 = 10;
    localparam int FB8 = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid4 = 1'b0, fault4 = 1'b0;
    logic [3:0]  data4  = '0;
    logic        ready4, tx4, busy4;
    logic [15:0] fc4;

    logic        valid8 = 1'b0, fault8 = 1'b0;
    logic [7:0]  data8  = '0;
    logic        ready8, tx8, busy8;
    logic [15:0] fc8;

    hamming_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(CPB)) dut4 (
        .clk(clk), .rst(rst), .in_valid(valid4), .in_data(data4), .in_fault(fault4),
        .in_ready(ready4), .tx_out(tx4), .tx_busy(busy4), .frame_count(fc4)
    );

    hamming_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut8 (
        .clk(clk), .rst(rst), .in_valid(valid8), .in_data(data8), .in_fault(fault8),
        .in_ready(ready8), .tx_out(tx8), .tx_busy(busy8), .frame_count(fc8)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fc_exp[2];
    logic [63:0] exp0[$];
    logic [63:0] exp1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic get_tx(int idx);     return (idx == 0) ? tx4 : tx8;       endfunction
    function automatic logic get_ready(int idx);  return (idx == 0) ? ready4 : ready8; endfunction
    function automatic logic get_busy(int idx);   return (idx == 0) ? busy4 : busy8;   endfunction
    function automatic logic [15:0] get_fc(int idx); return (idx == 0) ? fc4 : fc8;    endfunction

    task automatic drive(int idx, logic v, logic [7:0] d, logic f);
        if (idx == 0) begin valid4 = v; data4 = d[3:0]; fault4 = f; end
        else          begin valid8 = v; data8 = d;      fault8 = f; end
    endtask

    task automatic push_exp(int idx, logic [63:0] v);
        if (idx == 0) exp0.push_back(v);
        else          exp1.push_back(v);
    endtask

    function automatic bit pop_exp(int idx, output logic [63:0] v);
        v = '0;
        if (idx == 0) begin
            if (exp0.size() == 0) return 1'b0;
            v = exp0.pop_front();
        end else begin
            if (exp1.size() == 0) return 1'b0;
            v = exp1.pop_front();
        end
        return 1'b1;
    endfunction

    // Reference: expected line bits, first-sent bit at index 0.
    function automatic logic [63:0] model_frame(int width, int data, logic fault);
        logic [63:0] f;
        int pos;
        f   = '0;
        pos = 1;
        for (int b = 0; b < width / 4; b++) begin
            int nib;
            int d[4];
            nib = (data >> (4 * b)) % 16;
            for (int j = 0; j < 4; j++) d[j] = (nib >> j) % 2;
            for (int j = 0; j < 4; j++) begin f[pos] = d[j][0]; pos++; end
            f[pos] = 1'((d[0] + d[2] + d[3]) % 2); pos++;
            f[pos] = 1'((d[0] + d[1] + d[3]) % 2); pos++;
            f[pos] = 1'((d[0] + d[1] + d[2]) % 2); pos++;
        end
        f[pos] = fault;
        f[pos + 1] = 1'b1;
        return f;
    endfunction

    task automatic monitor(int idx);
        int fb;
        fb = (idx == 0) ? FB4 : FB8;
        forever begin
            @(negedge clk);
            if (rst) fc_exp[idx] = 0;
            else if (get_tx(idx) === 1'b0) begin
                logic [63:0] got;
                logic [63:0] expv;
                bit stable, aborted, have;
                got = '0; stable = 1'b1; aborted = 1'b0;
                for (int b = 0; b < fb && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        else if (c == 0) got[b] = get_tx(idx);
                        else if (get_tx(idx) !== got[b]) stable = 1'b0;
                    end
                end
                if (aborted) begin
                    fc_exp[idx] = 0;
                    void'(pop_exp(idx, expv));
                end else begin
                    have = pop_exp(idx, expv);
                    check($sformatf("dut%0d frame expected", idx), 64'(have), 64'd1);
                    if (have) check($sformatf("dut%0d frame bits", idx), got, expv);
                    check($sformatf("dut%0d bit hold", idx), 64'(stable), 64'd1);
                    fc_exp[idx] = (fc_exp[idx] + 1) % 65536;
                    check($sformatf("dut%0d frame_count", idx), 64'(get_fc(idx)), 64'(fc_exp[idx]));
                end
            end
        end
    endtask

    // Presents a word until accepted; optionally checks line/ready timing.
    task automatic send(int idx, logic [7:0] d, logic f, bit use_hand, logic [63:0] hand, bit chk_timing);
        int width, fb, n;
        bit acc;
        width = (idx == 0) ? 4 : 8;
        fb    = (idx == 0) ? FB4 : FB8;
        acc   = 1'b0;
        @(posedge clk); #1;
        drive(idx, 1'b1, d, f);
        for (int w = 0; w < 300 && !acc; w++) begin
            @(negedge clk);
            if (get_ready(idx)) begin
                acc = 1'b1;
                push_exp(idx, use_hand ? hand : model_frame(width, int'(d), f));
            end
            @(posedge clk); #1;
        end
        drive(idx, 1'b0, 8'($urandom), 1'($urandom));
        check($sformatf("dut%0d accepted", idx), 64'(acc), 64'd1);
        if (acc && chk_timing) begin
            for (n = 1; n <= fb * CPB + 10; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    check("busy after accept", 64'(get_busy(idx)), 64'd1);
                    check("line high in capture cycle", 64'(get_tx(idx)), 64'd1);
                end
                if (n == 2) check("start bit latency", 64'(get_tx(idx)), 64'd0);
                if (get_ready(idx)) break;
            end
            check($sformatf("dut%0d ready return cycle", idx), 64'(n), 64'(fb * CPB + 1));
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[$];

        // Reset held with valid high: nothing captured.
        drive(0, 1'b1, 8'h0A, 1'b1);
        drive(1, 1'b1, 8'h5A, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("reset tx4", 64'(tx4), 64'd1);
            check("reset tx8", 64'(tx8), 64'd1);
            check("reset ready4", 64'(ready4), 64'd0);
            check("reset ready8", 64'(ready8), 64'd0);
            check("reset busy4", 64'(busy4), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("ready4 after reset", 64'(ready4), 64'd1);
        check("ready8 after reset", 64'(ready8), 64'd1);
        check("fc4 after reset", 64'(fc4), 64'd0);
        check("fc8 after reset", 64'(fc8), 64'd0);
        check("busy8 after reset", 64'(busy8), 64'd0);

        // Hand-derived frames.
        send(0, 8'h0B, 1'b0, 1'b1, 64'h256,   1'b1);
        send(0, 8'h0F, 1'b1, 1'b1, 64'h3FE,   1'b1);
        send(0, 8'h00, 1'b0, 1'b1, 64'h200,   1'b1);
        send(1, 8'hB0, 1'b0, 1'b1, 64'h12B00, 1'b1);

        // Reset during DATA bit 3 of the 4-bit instance.
        send(0, 8'h09, 1'b1, 1'b0, 64'h0, 1'b0);
        repeat (4 * CPB + 2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("tx4 after mid-frame reset", 64'(tx4), 64'd1);
        check("fc4 after mid-frame reset", 64'(fc4), 64'd0);
        check("busy4 after mid-frame reset", 64'(busy4), 64'd0);
        check("ready4 after mid-frame reset", 64'(ready4), 64'd1);
        send(0, 8'h06, 1'b0, 1'b0, 64'h0, 1'b1);

        // Valid held high across three frames, data changing every cycle.
        @(posedge clk); #1;
        drive(0, 1'b1, 8'($urandom), 1'($urandom));
        for (int w = 0; w < 400 && acc_cyc.size() < 3; w++) begin
            @(negedge clk);
            if (ready4) begin
                push_exp(0, model_frame(4, int'(data4), fault4));
                acc_cyc.push_back(cyc);
            end
            @(posedge clk); #1;
            drive(0, 1'b1, 8'($urandom), 1'($urandom));
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        check("b2b accept count", 64'(acc_cyc.size()), 64'd3);
        if (acc_cyc.size() == 3) begin
            check("b2b gap 1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(FB4 * CPB + 1));
            check("b2b gap 2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(FB4 * CPB + 1));
        end

        // Randomized words on both widths.
        for (int idx = 0; idx < 2; idx++) begin
            for (int k = 0; k < 5; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send(idx, 8'($urandom), 1'($urandom), 1'b0, 64'h0, 1'b1);
            end
        end

        // Drain outstanding frames.
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            if (exp0.size() == 0 && exp1.size() == 0 && !busy4 && !busy8) break;
        end
        check("scoreboard drained", 64'(exp0.size() + exp1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_serial_tx.md
# hamming_serial_tx

Downstream consumer of the Hamming-protected shift register. It accepts the register's corrected parallel word through a valid/ready handshake and re-encodes every 4-bit block as a Hamming(7,4) codeword. It then serializes the frame (start bit, codewords, fault flag, stop bit) onto a single idle-high line at a programmable bit period. The link carries the data with per-nibble error protection in the same parity convention the register uses internally.

## Interface
- `WIDTH`, 4: data word width; must be a non-zero multiple of 4; `BLOCKS = WIDTH/4`.
- `CLKS_PER_BIT`, 4: clock cycles per transmitted bit; must be ≥ 2.
- One clock `clk`. Reset `rst` is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data`/`in_fault` valid this cycle.
- `in_data`  in  `WIDTH`  word to transmit (register's `parallel_out`).
- `in_fault`  in  1  word was corrected upstream (register's fault indication); sent as the flag bit.
- `in_ready`  out  1  block can accept a word this cycle.
- `tx_out`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  frame in progress.
- `frame_count`  out  16  frames fully transmitted, wraps at 2^16.

## Operation
- Parity per block `i`, with `d = in_data[4i+3:4i]`:
  - `p1 = d0^d2^d3`
  - `p2 = d0^d1^d3`
  - `p3 = d0^d1^d2`
- Codeword bit order on the line: `d0, d1, d2, d3, p1, p2, p3`. Block 0 is sent first.
- Frame layout:
  - start bit `0`
  - `7*BLOCKS` codeword bits
  - flag bit (`in_fault` as captured)
  - stop bit `1`
  - `FRAME_BITS = 7*BLOCKS + 3`.
- FSM states: IDLE, START, DATA, FLAG, STOP.
  - IDLE → START on `in_valid && in_ready`. The full frame is encoded and captured into a `7*BLOCKS+1`-bit shift register (codewords plus flag) on that edge.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → FLAG after `7*BLOCKS` bits.
  - FLAG → STOP after one bit.
  - STOP → IDLE after one bit; `frame_count` increments on that edge.
- Bit divider counts `0..CLKS_PER_BIT-1`. A bit advances when the divider reaches `CLKS_PER_BIT-1`. The bit counter counts data bits, width `$clog2(7*BLOCKS+1)`.
- Handshake:
  - `in_ready = (state==IDLE) && !rst`.
  - Words presented while not ready are ignored; no buffering.
  - `in_data`/`in_fault` need only be stable in the accept cycle.
- `tx_busy = (state != IDLE)`.
- `tx_out` is driven from a flop: `1` in IDLE and STOP, `0` in START, current shift-register LSB in DATA and FLAG.

## Timing
- Reset values: state IDLE, `tx_out=1`, `tx_busy=0`, `frame_count=0`, divider/bit counter 0. `in_ready=0` while `rst` is high, and `1` on the first cycle after release.
- Accept on edge k: `tx_out` goes `0` after edge k+1 and holds for `CLKS_PER_BIT` cycles. Each subsequent bit holds exactly `CLKS_PER_BIT` cycles.
- Frame occupies `FRAME_BITS*CLKS_PER_BIT` cycles after the one-cycle capture. `in_ready` reasserts the cycle after the last stop-bit cycle.
- Maximum throughput is one word per `FRAME_BITS*CLKS_PER_BIT + 1` cycles.
- Reset mid-frame: on the reset edge the frame is abandoned and `tx_out=1`; `frame_count` clears; a partial frame never increments `frame_count`.
- `rst` and `in_valid` high together: reset wins, no capture.
- `frame_count` wraps `16'hFFFF` → `0` without side effects.

## Structure
- Package `hamming_tx_pkg` holds:
  - state enum typedef `tx_state_t`
  - function `hamming74_parity(input [3:0]) → [2:0]`
  - function `frame_bits(blocks)`
  - constants for idle/start/stop levels.
- Sub-module `hamming74_encoder` (combinational, 4-bit data in, 7-bit codeword out in line order), instantiated `BLOCKS` times via generate.
- The top holds the FSM, divider, bit counter, shift register and frame counter.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid=1` → `tx_out=1`, `in_ready=0`, no frame; after release `in_ready=1`, `frame_count=0`.
- `WIDTH=4`, `CLKS_PER_BIT=4`, `in_data=4'b1011`, `in_fault=0` → line bits `0,1,1,0,1,0,1,0,0,1`, each 4 cycles (40 cycles total). `frame_count=1`, `in_ready` back on cycle 41.
- `in_data=4'hF`, `in_fault=1` → bits `0,1,1,1,1,1,1,1,1,1`. `in_data=4'h0` → `0,0,0,0,0,0,0,0,0,1`.
- `WIDTH=8`, `in_data=8'hB0` → block 0 codeword `0000000` first, then block 1 `1101010`. Frame is 17 bits (68 cycles).
- `in_valid` held high continuously across 3 frames → exactly one cycle of IDLE between frames. `frame_count` steps 1, 2, 3; mid-frame `in_data` changes are not transmitted.
- Assert `rst` during DATA bit 3 → `tx_out=1` on the next edge, `frame_count=0`. A new word accepted afterwards is sent intact.
